// File: rtl/jalu_seq_if.sv
// -----------------------------------------------------------------------------
// jalu_seq_if -- bundle of every non-clock signal of the jalu_seq sequencer.
//
// Groups:
//   request side : wreq_valid, wreq_ready, breq_a, breq_b, breq_op,
//                  wreq_ci, wreq_cc, wreq_cmp
//   ALU drive    : balu_a, balu_b, walu_ci, balu_op
//   ALU return   : balu_c, walu_co, walu_eq, walu_al, walu_z
//   result side  : bres, bflags {C,A,E,Z}, wdone
//
// Modports:
//   slave  : the sequencer's view (jalu_seq uses this one)
//   master : the requester / ALU-side view
// -----------------------------------------------------------------------------
interface jalu_seq_if;
  // Request handshake and operands
  logic       wreq_valid;
  logic       wreq_ready;
  logic [7:0] breq_a;
  logic [7:0] breq_b;
  logic [2:0] breq_op;
  logic       wreq_ci;
  logic       wreq_cc;
  logic       wreq_cmp;

  // Drive toward the external ALU
  logic [7:0] balu_a;
  logic [7:0] balu_b;
  logic       walu_ci;
  logic [2:0] balu_op;

  // Results from the external ALU
  logic [7:0] balu_c;
  logic       walu_co;
  logic       walu_eq;
  logic       walu_al;
  logic       walu_z;

  // Registered results
  logic [7:0] bres;
  logic [3:0] bflags;
  logic       wdone;

  modport slave (
    input  wreq_valid, breq_a, breq_b, breq_op, wreq_ci, wreq_cc, wreq_cmp,
    output wreq_ready,
    output balu_a, balu_b, walu_ci, balu_op,
    input  balu_c, walu_co, walu_eq, walu_al, walu_z,
    output bres, bflags, wdone
  );

  modport master (
    output wreq_valid, breq_a, breq_b, breq_op, wreq_ci, wreq_cc, wreq_cmp,
    input  wreq_ready,
    input  balu_a, balu_b, walu_ci, balu_op,
    output balu_c, walu_co, walu_eq, walu_al, walu_z,
    input  bres, bflags, wdone
  );
endinterface

// File: rtl/jalu_seq.sv
// -----------------------------------------------------------------------------
// jalu_seq -- five-state sequencer that feeds an external combinational ALU.
//
// A request accepted in IDLE has its operands captured, then B is presented
// (LDB), then A/op/carry-in (LDA), the ALU result is captured at the end of EXE
// and a one-cycle wdone pulse is raised in DONE. Throughput is one op per five
// cycles; requests are only accepted while wreq_ready (IDLE) is high.
//
// Ports:
//   wclk    : clock, rising edge
//   wreset  : synchronous active-high reset, aborts any op in flight
//   bus     : jalu_seq_if.slave (request, ALU drive/return, result signals)
//
// Build option:
//   JALU_SEQ_CARRY_CHAIN_EN -- when defined, a request with wreq_cc=1 uses the
//   stored C flag as ALU carry-in instead of wreq_ci. When undefined, wreq_cc
//   is ignored and carry-in is always the latched wreq_ci.
// -----------------------------------------------------------------------------
module jalu_seq (
  input  logic        wclk,
  input  logic        wreset,
  jalu_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDB  = 3'd1,
    S_LDA  = 3'd2,
    S_EXE  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [2:0] OP_NONE = 3'd7;

  state_t     r_state;
  state_t     w_state_next;

  // Operands captured at the accept edge
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [2:0] r_op;
  logic       r_ci;
  logic       r_cmp;
`ifdef JALU_SEQ_CARRY_CHAIN_EN
  logic       r_cc;
`endif

  logic [7:0] r_res;
  logic [3:0] r_flags;   // {C, A, E, Z}

  logic       w_accept;
  logic       w_ready;
  logic       w_done;
  logic [7:0] w_alu_a;
  logic [7:0] w_alu_b;
  logic [2:0] w_alu_op;
  logic       w_alu_ci;
  logic       w_ci_sel;
  logic       w_c_next;

  // Carry-in presented during LDA/EXE. C is only rewritten at the EXE edge,
  // so during an op the stored C still belongs to the previous op.
`ifdef JALU_SEQ_CARRY_CHAIN_EN
  assign w_ci_sel = r_cc ? r_flags[3] : r_ci;
`else
  assign w_ci_sel = r_ci;
`endif

  assign w_accept = (r_state == S_IDLE) && bus.wreq_valid;

  // Only arithmetic/shift ops produce a meaningful carry-out.
  assign w_c_next = (r_op <= 3'd2) ? bus.walu_co : 1'b0;

  // State register
  always_ff @(posedge wclk) begin
    if (wreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and per-state ALU drive
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_done       = 1'b0;
    w_alu_a      = 8'h00;
    w_alu_b      = 8'h00;
    w_alu_op     = OP_NONE;
    w_alu_ci     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.wreq_valid) begin
          w_state_next = S_LDB;
        end
      end
      S_LDB: begin
        w_alu_b      = r_b;
        w_state_next = S_LDA;
      end
      S_LDA: begin
        w_alu_a      = r_a;
        w_alu_b      = r_b;
        w_alu_op     = r_op;
        w_alu_ci     = w_ci_sel;
        w_state_next = S_EXE;
      end
      S_EXE: begin
        w_alu_a      = r_a;
        w_alu_b      = r_b;
        w_alu_op     = r_op;
        w_alu_ci     = w_ci_sel;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        w_alu_b      = r_b;
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand capture and result/flag registers
  always_ff @(posedge wclk) begin
    if (wreset) begin
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_op    <= 3'd0;
      r_ci    <= 1'b0;
      r_cmp   <= 1'b0;
`ifdef JALU_SEQ_CARRY_CHAIN_EN
      r_cc    <= 1'b0;
`endif
      r_res   <= 8'h00;
      r_flags <= 4'h0;
    end else begin
      if (w_accept) begin
        r_a   <= bus.breq_a;
        r_b   <= bus.breq_b;
        r_op  <= bus.breq_op;
        r_ci  <= bus.wreq_ci;
        r_cmp <= bus.wreq_cmp;
`ifdef JALU_SEQ_CARRY_CHAIN_EN
        r_cc  <= bus.wreq_cc;
`endif
      end
      if (r_state == S_EXE) begin
        // Compare ops leave the result register untouched.
        if (!r_cmp) begin
          r_res <= bus.balu_c;
        end
        r_flags <= {w_c_next, bus.walu_al, bus.walu_eq, bus.walu_z};
      end
    end
  end

  assign bus.wreq_ready = w_ready;
  assign bus.wdone      = w_done;
  assign bus.balu_a     = w_alu_a;
  assign bus.balu_b     = w_alu_b;
  assign bus.balu_op    = w_alu_op;
  assign bus.walu_ci    = w_alu_ci;
  assign bus.bres       = r_res;
  assign bus.bflags     = r_flags;

endmodule

// File: tb/tb_jalu_seq.sv
// -----------------------------------------------------------------------------
// tb_jalu_seq -- directed self-checking bench for jalu_seq.
// Plays the role of requester and of the external combinational ALU.
// Flags are {C, A, E, Z}; A means operand A greater than operand B.
// -----------------------------------------------------------------------------
module tb_jalu_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  jalu_seq_if bus ();

  jalu_seq dut (
    .wclk   (clk),
    .wreset (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model
  logic [8:0] alu_sum;
  logic [7:0] alu_c;
  logic       alu_co;
  always_comb begin
    alu_sum = {1'b0, bus.balu_a} + {1'b0, bus.balu_b} + {8'h00, bus.walu_ci};
    alu_c   = 8'h00;
    alu_co  = 1'b0;
    case (bus.balu_op)
      3'd0: begin alu_c = alu_sum[7:0]; alu_co = alu_sum[8]; end
      3'd1: begin alu_c = {bus.walu_ci, bus.balu_a[7:1]}; alu_co = bus.balu_a[0]; end
      3'd2: begin alu_c = {bus.balu_a[6:0], bus.walu_ci}; alu_co = bus.balu_a[7]; end
      3'd3: alu_c = ~bus.balu_a;
      3'd4: alu_c = bus.balu_a & bus.balu_b;
      3'd5: alu_c = bus.balu_a | bus.balu_b;
      3'd6: alu_c = bus.balu_a ^ bus.balu_b;
      default: alu_c = 8'h00;
    endcase
  end
  assign bus.balu_c  = alu_c;
  assign bus.walu_co = alu_co;
  assign bus.walu_eq = (bus.balu_a == bus.balu_b);
  assign bus.walu_al = (bus.balu_a > bus.balu_b);
  assign bus.walu_z  = (alu_c == 8'h00);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic ci, input logic cc, input logic cmp);
    bus.breq_a   = a;
    bus.breq_b   = b;
    bus.breq_op  = op;
    bus.wreq_ci  = ci;
    bus.wreq_cc  = cc;
    bus.wreq_cmp = cmp;
  endtask

  // Issue one request from IDLE; lat = edges from accept until wdone is seen
  // (10 means it never came). Returns with the DUT back in IDLE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic ci, input logic cc, input logic cmp, output int lat);
    set_req(a, b, op, ci, cc, cmp);
    bus.wreq_valid = 1'b1;
    tick();
    bus.wreq_valid = 1'b0;
    lat = 0;
    while (!bus.wdone && lat < 10) begin
      tick();
      lat++;
    end
    $display("op=%0d a=%02h b=%02h ci=%0b cc=%0b cmp=%0b -> bres=%02h flags=%04b lat=%0d",
             op, a, b, ci, cc, cmp, bus.bres, bus.bflags, lat);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wreq_valid = 1'b0;
    set_req(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.wreq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", bus.wreq_ready); end
    checks++; if (bus.bres !== 8'h00) begin errors++; $display("FAIL reset_bres got %02h want 00", bus.bres); end
    checks++; if (bus.bflags !== 4'h0) begin errors++; $display("FAIL reset_flags got %04b want 0000", bus.bflags); end
    checks++; if (bus.wdone !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", bus.wdone); end
    checks++; if ({bus.balu_a, bus.balu_b, bus.balu_op, bus.walu_ci} !== {8'h00, 8'h00, 3'd7, 1'b0}) begin
      errors++; $display("FAIL reset_alu_drive got a=%02h b=%02h op=%0d ci=%0b want 00 00 7 0",
                         bus.balu_a, bus.balu_b, bus.balu_op, bus.walu_ci);
    end
    $display("reset done");
  endtask

  // ADD 0x0F+0x01 stepped by hand, checking the ALU drive in every state.
  task automatic test_add();
    set_req(8'h0F, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0);
    bus.wreq_valid = 1'b1;
    tick();                 // accept edge -> LDB
    bus.wreq_valid = 1'b0;
    checks++; if ({bus.wreq_ready, bus.balu_a, bus.balu_b, bus.balu_op} !== {1'b0, 8'h00, 8'h01, 3'd7}) begin
      errors++; $display("FAIL add_ldb got rdy=%0b a=%02h b=%02h op=%0d want 0 00 01 7",
                         bus.wreq_ready, bus.balu_a, bus.balu_b, bus.balu_op);
    end
    tick();                 // LDA
    checks++; if ({bus.balu_a, bus.balu_b, bus.balu_op, bus.wdone} !== {8'h0F, 8'h01, 3'd0, 1'b0}) begin
      errors++; $display("FAIL add_lda got a=%02h b=%02h op=%0d done=%0b want 0f 01 0 0",
                         bus.balu_a, bus.balu_b, bus.balu_op, bus.wdone);
    end
    tick();                 // EXE
    checks++; if (bus.wdone !== 1'b0) begin errors++; $display("FAIL add_exe_done got %0b want 0", bus.wdone); end
    tick();                 // DONE
    checks++; if (bus.wdone !== 1'b1) begin errors++; $display("FAIL add_done got %0b want 1", bus.wdone); end
    checks++; if (bus.bres !== 8'h10) begin errors++; $display("FAIL add_bres got %02h want 10", bus.bres); end
    checks++; if (bus.bflags !== 4'b0100) begin errors++; $display("FAIL add_flags got %04b want 0100", bus.bflags); end
    checks++; if (bus.balu_a !== 8'h00 || bus.balu_op !== 3'd7) begin
      errors++; $display("FAIL add_done_drive got a=%02h op=%0d want 00 7", bus.balu_a, bus.balu_op);
    end
    $display("op=0 a=0f b=01 -> bres=%02h flags=%04b", bus.bres, bus.bflags);
    tick();                 // IDLE
    checks++; if ({bus.wdone, bus.wreq_ready} !== 2'b01) begin
      errors++; $display("FAIL add_idle got done=%0b rdy=%0b want 0 1", bus.wdone, bus.wreq_ready);
    end
    tick();
    tick();
    checks++; if (bus.bres !== 8'h10 || bus.bflags !== 4'b0100) begin
      errors++; $display("FAIL add_hold got bres=%02h flags=%04b want 10 0100", bus.bres, bus.bflags);
    end
  endtask

  // SHR with ci=1: carry-in must reach the ALU only in LDA/EXE.
  task automatic test_shr_ci();
    set_req(8'h02, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0);
    bus.wreq_valid = 1'b1;
    tick();
    bus.wreq_valid = 1'b0;
    checks++; if (bus.walu_ci !== 1'b0) begin errors++; $display("FAIL shr_ci_ldb got %0b want 0", bus.walu_ci); end
    tick();
    checks++; if (bus.walu_ci !== 1'b1) begin errors++; $display("FAIL shr_ci_lda got %0b want 1", bus.walu_ci); end
    tick();
    tick();
    checks++; if (bus.bres !== 8'h81 || bus.bflags !== 4'b0100) begin
      errors++; $display("FAIL shr_result got bres=%02h flags=%04b want 81 0100", bus.bres, bus.bflags);
    end
    checks++; if (bus.walu_ci !== 1'b0) begin errors++; $display("FAIL shr_ci_done got %0b want 0", bus.walu_ci); end
    $display("op=1 a=02 b=00 ci=1 -> bres=%02h flags=%04b", bus.bres, bus.bflags);
    tick();
  endtask

  task automatic test_carry_chain();
    int lat;
    run_op(8'hFF, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL chain1_latency got %0d want 3", lat); end
    checks++; if (bus.bres !== 8'h00 || bus.bflags !== 4'b1101) begin
      errors++; $display("FAIL chain1_result got bres=%02h flags=%04b want 00 1101", bus.bres, bus.bflags);
    end
    run_op(8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, lat);
`ifdef JALU_SEQ_CARRY_CHAIN_EN
    checks++; if (bus.bres !== 8'h01 || bus.bflags !== 4'b0010) begin
      errors++; $display("FAIL chain2_result got bres=%02h flags=%04b want 01 0010", bus.bres, bus.bflags);
    end
`else
    checks++; if (bus.bres !== 8'h00 || bus.bflags !== 4'b0011) begin
      errors++; $display("FAIL chain2_result got bres=%02h flags=%04b want 00 0011", bus.bres, bus.bflags);
    end
`endif
  endtask

  task automatic test_cmp();
    int lat;
    run_op(8'h0F, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0, lat);
    checks++; if (bus.bres !== 8'h10) begin errors++; $display("FAIL cmp_setup got %02h want 10", bus.bres); end
    run_op(8'h55, 8'h55, 3'd6, 1'b0, 1'b0, 1'b1, lat);
    checks++; if (bus.bres !== 8'h10 || bus.bflags !== 4'b0011) begin
      errors++; $display("FAIL cmp_result got bres=%02h flags=%04b want 10 0011", bus.bres, bus.bflags);
    end
  endtask

  task automatic test_op7();
    int lat;
    run_op(8'h05, 8'h03, 3'd7, 1'b1, 1'b0, 1'b0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL op7_latency got %0d want 3", lat); end
    checks++; if (bus.bres !== 8'h00 || bus.bflags !== 4'b0101) begin
      errors++; $display("FAIL op7_result got bres=%02h flags=%04b want 00 0101", bus.bres, bus.bflags);
    end
  endtask

  // Operand changes after the accept edge must not affect the op in flight.
  task automatic test_input_change();
    int lat;
    set_req(8'hF0, 8'h3C, 3'd4, 1'b0, 1'b0, 1'b0);
    bus.wreq_valid = 1'b1;
    tick();
    bus.wreq_valid = 1'b0;
    lat = 0;
    while (!bus.wdone && lat < 10) begin
      set_req(8'hFF, 8'h00, 3'd5, 1'b1, 1'b1, 1'b1);
      tick();
      lat++;
    end
    checks++; if (bus.bres !== 8'h30 || bus.bflags !== 4'b0100 || lat !== 3) begin
      errors++; $display("FAIL input_change got bres=%02h flags=%04b lat=%0d want 30 0100 3",
                         bus.bres, bus.bflags, lat);
    end
    $display("op=4 a=f0 b=3c (inputs disturbed) -> bres=%02h flags=%04b", bus.bres, bus.bflags);
    tick();
  endtask

  task automatic test_back_to_back();
    int rdy_cnt;
    int done_cnt;
    int first_rdy;
    int last_rdy;
    rdy_cnt = 0; done_cnt = 0; first_rdy = -1; last_rdy = -1;
    set_req(8'h81, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0);
    bus.wreq_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (bus.wreq_ready) begin
        rdy_cnt++;
        if (first_rdy < 0) first_rdy = i;
        last_rdy = i;
      end
      if (bus.wdone) done_cnt++;
      if (i != 14) tick();
    end
    checks++; if (rdy_cnt !== 3 || first_rdy !== 0 || last_rdy !== 10) begin
      errors++; $display("FAIL b2b_ready got cnt=%0d first=%0d last=%0d want 3 0 10", rdy_cnt, first_rdy, last_rdy);
    end
    checks++; if (done_cnt !== 3) begin errors++; $display("FAIL b2b_done got %0d want 3", done_cnt); end
    checks++; if (bus.wdone !== 1'b1 || bus.bres !== 8'h02 || bus.bflags !== 4'b1100) begin
      errors++; $display("FAIL b2b_result got done=%0b bres=%02h flags=%04b want 1 02 1100",
                         bus.wdone, bus.bres, bus.bflags);
    end
    $display("b2b shl a=81: ready=%0d done=%0d bres=%02h flags=%04b", rdy_cnt, done_cnt, bus.bres, bus.bflags);
    bus.wreq_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    int done_seen;
    done_seen = 0;
    set_req(8'h0F, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0);
    bus.wreq_valid = 1'b1;
    tick();                 // LDB
    bus.wreq_valid = 1'b0;
    tick();                 // LDA
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({bus.wreq_ready, bus.wdone, bus.bres, bus.bflags} !== {1'b1, 1'b0, 8'h00, 4'h0}) begin
      errors++; $display("FAIL abort_state got rdy=%0b done=%0b bres=%02h flags=%04b want 1 0 00 0000",
                         bus.wreq_ready, bus.wdone, bus.bres, bus.bflags);
    end
    for (int i = 0; i < 5; i++) begin
      if (bus.wdone) done_seen++;
      tick();
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_seen); end
    $display("reset in LDA -> bres=%02h flags=%04b", bus.bres, bus.bflags);
  endtask

  task automatic test_reset_dominates();
    set_req(8'hAA, 8'h55, 3'd5, 1'b0, 1'b0, 1'b0);
    bus.wreq_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.wreq_valid = 1'b0;
    checks++; if (bus.wreq_ready !== 1'b1 || bus.balu_b !== 8'h00) begin
      errors++; $display("FAIL rst_dominates got rdy=%0b b=%02h want 1 00", bus.wreq_ready, bus.balu_b);
    end
    tick();
    checks++; if (bus.wreq_ready !== 1'b1 || bus.wdone !== 1'b0) begin
      errors++; $display("FAIL rst_dominates_idle got rdy=%0b done=%0b want 1 0", bus.wreq_ready, bus.wdone);
    end
    $display("reset with valid -> ready=%0b", bus.wreq_ready);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.wreq_valid = 1'b0;
    set_req(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_add();
    test_shr_ci();
    test_carry_chain();
    test_cmp();
    test_op7();
    test_input_change();
    test_back_to_back();
    test_reset_abort();
    test_reset_dominates();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jalu_seq.md
JALU_SEQ -- requirements
Module: jalu_seq

Interface
REQ-001 Clock and reset SHALL be one clock and synchronous active-high reset: wclk input 1 (rising edge), wreset input 1 (sync, active-high).
REQ-002 wreq_valid input 1: request present.
REQ-003 wreq_ready output 1: sequencer can accept.
REQ-004 breq_a / breq_b input 8 each: operands A / B.
REQ-005 breq_op input 3: 0 ADD, 1 SHR, 2 SHL, 3 NOT, 4 AND, 5 OR, 6 XOR, 7 none.
REQ-006 wreq_ci input 1: carry-in; wreq_cc input 1: use stored C as carry-in (macro-gated); wreq_cmp input 1: flags-only (compare).
REQ-007 balu_a, balu_b output 8, walu_ci output 1, balu_op output 3: drive the external ALU.
REQ-008 balu_c input 8, walu_co / walu_eq / walu_al / walu_z input 1: ALU results.
REQ-009 bres output 8: result register; bflags output 4 {C,A,E,Z}; wdone output 1: completion pulse.

Function
REQ-010 FSM SHALL have states IDLE, LDB, LDA, EXE, DONE; wreq_ready = 1 only in IDLE.
REQ-011 IDLE: wreq_valid=1 at edge -> latch A, B, op, ci, cc, cmp into internal TMP registers; go LDB; wreq_valid=0 -> stay IDLE.
REQ-012 LDB -> LDA -> EXE unconditionally, one cycle each; EXE -> DONE; DONE -> IDLE.
REQ-013 balu_b SHALL be 0 in IDLE, latched B from LDB onward; balu_a 0 until LDA, latched A in LDA and EXE; balu_op = 7 except in LDA/EXE, where it equals latched op.
REQ-014 At the EXE edge: bres <= balu_c unless latched cmp=1 (bres unchanged); bflags always updated.
REQ-015 Flags: A <= walu_al, E <= walu_eq, Z <= walu_z; C <= walu_co for op 0..2, C <= 0 for op 3..7.
REQ-016 wdone SHALL be 1 exactly in DONE (one cycle); latency: accepted at edge N -> wdone high during cycle after edge N+3.
REQ-017 Requests while wreq_ready=0 SHALL be ignored; inputs sampled only at accept edge; later changes have no effect on the op in flight.
REQ-018 Accept and DONE never overlap; back-to-back throughput is one op per 5 cycles.
REQ-019 op 7 SHALL complete normally: bres <= ALU output (0), Z <= 1.
REQ-020 bres and bflags SHALL hold value between completions.

Reset
REQ-021 wreset=1 at an edge SHALL force IDLE, bres=0, bflags=0, wdone=0, all latched operands=0, regardless of state; an op in flight is aborted with no wdone.
REQ-022 wreset dominates wreq_valid on the same edge; the request is not accepted.

Configuration
REQ-023 Macro JALU_SEQ_CARRY_CHAIN_EN: defined -> walu_ci = stored C when latched cc=1, else latched ci; undefined -> walu_ci = latched ci, wreq_cc ignored (port retained).
REQ-024 walu_ci SHALL be 0 outside LDA/EXE in both builds.

Verification
REQ-025 ADD A=0x0F B=0x01 ci=0 -> wdone at accept+4 cycles, bres=0x10, flags C=0 A=1 E=0 Z=0.
REQ-026 ADD A=0xFF B=0x01 then (macro defined) ADD A=0x00 B=0x00 cc=1 -> bres 0x00 C=1 Z=1, then bres 0x01 C=0; undefined build -> second bres 0x00.
REQ-027 XOR cmp=1 A=0x55 B=0x55 after bres=0x10 -> bres stays 0x10, E=1 Z=1 A=0.
REQ-028 wreq_valid held high continuously with SHL A=0x81 ci=0 -> bres=0x02 C=1, accepts spaced exactly 5 cycles, wreq_ready low 4 of 5.
REQ-029 wreset pulsed in LDA -> no wdone, bres=0, bflags=0, wreq_ready=1 next cycle.
REQ-030 Change breq_a/breq_op during LDB..EXE -> result reflects accept-time values only.
